kernel_cc_fifo_rr_arb: RTL and testbench
========================================

Name: kernel_cc_fifo_rr_arb

Overview:
- Round-robin arbiter that merges NUM_IN ap_fifo-style producer streams into one shared downstream FIFO, such as the 32-bit depth-4 shift-register FIFOs feeding the CC kernel datapath.
- A requester holds the grant for a burst of up to MAX_BURST words, or until it drains.
- The arbiter then advances fairly to the next requester.
- It sits between the upstream FIFO read ports and the shared FIFO write port.

Parameters:
- NUM_IN, 4: number of requesters, 2..16.
- DATA_WIDTH, 32: word width.
- SEL_WIDTH, 2: grant index width; must satisfy 2^SEL_WIDTH >= NUM_IN.
- MAX_BURST, 8: maximum words per grant, >= 1.
- CNT_WIDTH, 4: burst counter width; must hold MAX_BURST.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  allows new grants; does not abort a burst in progress.
- in_empty_n  in  NUM_IN  per-requester "data available".
- in_dout  in  NUM_IN*DATA_WIDTH  requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_read  out  NUM_IN  per-requester read strobe.
- out_full_n  in  1  downstream FIFO "space available".
- out_write  out  1  downstream write strobe.
- out_din  out  DATA_WIDTH  downstream write data.
- grant_valid  out  1  high while in state GRANT.
- grant_idx  out  SEL_WIDTH  current/last granted requester.
- word_cnt  out  32  total words transferred; wraps modulo 2^32.

Behaviour:
- Reset (synchronous, active-high, takes priority over all other activity):
  - state=IDLE, rr_ptr=0, grant_idx=0, burst_cnt=0, word_cnt=0.
  - Consequently in_read=0, out_write=0, grant_valid=0.
  - out_din is don't-care when out_write=0; drive it from in_dout[grant_idx].
- Reset mid-burst drops the grant immediately. No word is transferred in the reset cycle: strobes are forced low while reset=1.
- State IDLE:
  - No transfers; in_read=0, out_write=0.
  - If en=1 and any in_empty_n bit is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... with wrap at NUM_IN-1 -> 0.
  - On a pick: load grant_idx, clear burst_cnt, go to GRANT on the next edge.
  - Arbitration latency is 1 cycle: the first transfer can occur in the cycle after the request is seen.
- State GRANT, with g=grant_idx. Evaluate the following in order:
  - If in_empty_n[g]=0 (drained): no transfer; release.
  - Else if out_full_n=1: transfer.
    - in_read[g]=1, out_write=1, out_din=in_dout[g] (combinational, same cycle).
    - word_cnt+1, burst_cnt+1.
    - If burst_cnt==MAX_BURST-1, release after this transfer.
  - Else (out_full_n=0): stall. No strobes; hold state, burst_cnt and grant.
- Release:
  - state<=IDLE, burst_cnt<=0.
  - rr_ptr <= (g==NUM_IN-1) ? 0 : g+1.
  - grant_idx keeps its value.
- Invariants:
  - At most one in_read bit is high per cycle.
  - in_read[g] == out_write at all times.
  - in_read and out_write are never high while in_empty_n[g]=0 or out_full_n=0.
- Throughput: one word per cycle within a burst. Each new grant costs 1 IDLE cycle, so max efficiency is MAX_BURST/(MAX_BURST+1).
- en=0 in GRANT has no effect; the burst completes normally.
- NUM_IN not a power of 2: requester indices >= NUM_IN are never granted.
- in_dout and out_full_n may change every cycle; the block samples only the current cycle's values.

Test Plan:
- Single requester: reset, en=1. Requester 0 holds 3 words A,B,C; out_full_n=1.
  - Required: grant in cycle 1, writes A,B,C in cycles 2-4 with in_read[0]=1.
  - Cycle 5 releases on empty; word_cnt=3, rr_ptr=1.
- Burst fairness: MAX_BURST=8. Requesters 0 and 2 continuously non-empty.
  - Required: 8 words from 0, 1 idle cycle, 8 words from 2, 1 idle cycle, then 0 again.
  - word_cnt=32 after two full rounds.
- Back-pressure: requester 1 is granted. Drop out_full_n for 3 cycles after its 2nd word.
  - Required: no strobes during the stall; grant and burst_cnt=2 held.
  - Transfers resume when out_full_n returns to 1, and the burst still ends at 8 words total.
- Round-robin wrap: NUM_IN=4. All requesters hold 1 word each.
  - Required: grant order 0,1,2,3. Then rr_ptr=0, and a new word on 3 only is granted after a scan from 0.
- Reset mid-burst: assert reset during the 4th word of a burst.
  - Required: no strobes in the reset cycle.
  - Next cycle: state IDLE, word_cnt=0, rr_ptr=0, grant_valid=0.
- Enable gating: en=0 with all requesters non-empty.
  - Required: stays in IDLE, no grants.
  - Deasserting en mid-burst lets the burst finish, then no new grant is issued.

Source files
------------

// File: rtl/kernel_cc_fifo_rr_arb.sv
// Round-robin merge of NUM_IN ap_fifo producer streams into one shared downstream FIFO.
// A grant lasts up to MAX_BURST words or until the granted stream drains.
//
// state | meaning
// IDLE  | no grant; scan requesters from rr_ptr and latch the first ready one
// GRANT | move one word per cycle from grant_idx while downstream has space
module kernel_cc_fifo_rr_arb #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 2,
  parameter int MAX_BURST  = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [NUM_IN-1:0]            in_empty_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
  output logic [NUM_IN-1:0]            in_read,
  input  logic                         out_full_n,
  output logic                         out_write,
  output logic [DATA_WIDTH-1:0]        out_din,
  output logic                         grant_valid,
  output logic [SEL_WIDTH-1:0]         grant_idx,
  output logic [31:0]                  word_cnt
);

  localparam int NSEL = 2 ** SEL_WIDTH;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic [SEL_WIDTH-1:0]  rr_ptr, rr_ptr_nxt, grant_idx_nxt, release_ptr;
  logic [CNT_WIDTH-1:0]  burst_cnt, burst_cnt_nxt;
  logic [31:0]           word_cnt_nxt;
  logic [NSEL-1:0]       avail;
  logic [DATA_WIDTH-1:0] dout_arr [NSEL];
  logic [2*NUM_IN-1:0]   avail_rot;
  logic [SEL_WIDTH:0]    pick_sum;
  logic [SEL_WIDTH-1:0]  pick_idx;
  logic                  pick_found;
  logic                  xfer;

  // Pad to the full index range so unused indices read as never-ready.
  for (genvar i = 0; i < NSEL; i++) begin : g_pad
    if (i < NUM_IN) begin : g_real
      assign avail[i]    = in_empty_n[i];
      assign dout_arr[i] = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_unused
      assign avail[i]    = 1'b0;
      assign dout_arr[i] = '0;
    end
  end

  // Rotate so bit k is requester rr_ptr+k; lowest set bit wins.
  assign avail_rot = {in_empty_n, in_empty_n} >> rr_ptr;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_sum   = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (avail_rot[k]) begin
        pick_found = 1'b1;
        pick_sum   = {1'b0, rr_ptr} + (SEL_WIDTH+1)'(k);
        if (pick_sum >= (SEL_WIDTH+1)'(NUM_IN))
          pick_sum = pick_sum - (SEL_WIDTH+1)'(NUM_IN);
        pick_idx   = pick_sum[SEL_WIDTH-1:0];
      end
    end
  end

  assign release_ptr = (grant_idx == SEL_WIDTH'(NUM_IN - 1)) ? '0
                                                             : grant_idx + SEL_WIDTH'(1);

  assign xfer        = (state == GRANT) && !reset && avail[grant_idx] && out_full_n;
  assign out_write   = xfer;
  assign out_din     = dout_arr[grant_idx];
  assign grant_valid = (state == GRANT) && !reset;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++)
      in_read[i] = xfer && (grant_idx == SEL_WIDTH'(i));
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_idx_nxt = grant_idx;
    burst_cnt_nxt = burst_cnt;
    word_cnt_nxt  = word_cnt;
    case (state)
      IDLE: begin
        if (en && pick_found) begin
          state_nxt     = GRANT;
          grant_idx_nxt = pick_idx;
          burst_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!avail[grant_idx]) begin
          state_nxt     = IDLE;
          burst_cnt_nxt = '0;
          rr_ptr_nxt    = release_ptr;
        end else if (out_full_n) begin
          word_cnt_nxt  = word_cnt + 32'd1;
          burst_cnt_nxt = burst_cnt + CNT_WIDTH'(1);
          if (burst_cnt == CNT_WIDTH'(MAX_BURST - 1)) begin
            state_nxt     = IDLE;
            burst_cnt_nxt = '0;
            rr_ptr_nxt    = release_ptr;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      burst_cnt <= '0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_idx <= grant_idx_nxt;
      burst_cnt <= burst_cnt_nxt;
      word_cnt  <= word_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_kernel_cc_fifo_rr_arb.sv
// Directed bench for kernel_cc_fifo_rr_arb: bench-side producer queues, a grant/burst
// model checked every cycle, and literal expectations for each scenario.
module tb_kernel_cc_fifo_rr_arb;

  localparam int NI = 4;
  localparam int DW = 32;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [NI-1:0]   in_empty_n;
  logic [NI*DW-1:0] in_dout;
  logic [NI-1:0]   in_read;
  logic            out_full_n;
  logic            out_write;
  logic [DW-1:0]   out_din;
  logic            grant_valid;
  logic [1:0]      grant_idx;
  logic [31:0]     word_cnt;

  kernel_cc_fifo_rr_arb #(
    .NUM_IN(NI), .DATA_WIDTH(DW), .SEL_WIDTH(2), .MAX_BURST(MB), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .in_empty_n(in_empty_n), .in_dout(in_dout), .in_read(in_read),
    .out_full_n(out_full_n), .out_write(out_write), .out_din(out_din),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // producer queues
  logic [31:0] mem [NI][64];
  int head [NI];
  int tail [NI];

  // control applied at the next falling edge
  logic c_reset, c_en, c_full;

  // model: owner=-1 means nobody holds the grant
  int          m_owner, m_burst, m_rr, m_last;
  int unsigned m_words;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic push(input int r, input logic [31:0] d);
    mem[r][tail[r]] = d;
    tail[r]++;
  endtask

  task automatic clear_q();
    for (int i = 0; i < NI; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic tick();
    logic [NI-1:0] exp_rd;
    logic          exp_wr;
    logic [31:0]   exp_din;
    bit            found;
    bit            rel;
    int            idx;
    int            g;
    @(negedge clk);
    reset      = c_reset;
    en         = c_en;
    out_full_n = c_full;
    for (int i = 0; i < NI; i++) begin
      in_empty_n[i]       = (tail[i] != head[i]);
      in_dout[i*DW +: DW] = in_empty_n[i] ? mem[i][head[i]] : (32'hDEAD_0000 + 32'(i));
    end
    #1;
    exp_rd  = '0;
    exp_wr  = 1'b0;
    exp_din = '0;
    if (!c_reset && m_owner >= 0 && tail[m_owner] != head[m_owner] && c_full) begin
      exp_wr          = 1'b1;
      exp_rd[m_owner] = 1'b1;
      exp_din         = mem[m_owner][head[m_owner]];
    end
    check("grant_valid", 32'(grant_valid), 32'(!c_reset && m_owner >= 0));
    check("grant_idx", 32'(grant_idx), 32'(m_last));
    check("word_cnt", word_cnt, m_words);
    check("in_read", 32'(in_read), 32'(exp_rd));
    check("out_write", 32'(out_write), 32'(exp_wr));
    if (exp_wr) check("out_din", out_din, exp_din);

    rel = 1'b0;
    g   = m_owner;
    if (c_reset) begin
      m_owner = -1; m_rr = 0; m_last = 0; m_burst = 0; m_words = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      if (c_en) begin
        for (int k = 0; k < NI; k++) begin
          idx = (m_rr + k) % NI;
          if (!found && tail[idx] != head[idx]) begin
            found = 1'b1; m_owner = idx; m_last = idx; m_burst = 0;
          end
        end
      end
    end else if (tail[g] == head[g]) begin
      rel = 1'b1;
    end else if (c_full) begin
      head[g]++;
      m_words++;
      m_burst++;
      if (m_burst == MB) rel = 1'b1;
    end
    if (rel) begin
      m_owner = -1; m_burst = 0; m_rr = (g + 1) % NI;
    end
  endtask

  task automatic do_reset();
    clear_q();
    c_reset = 1'b1;
    tick();
    c_reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; out_full_n = 1'b1;
    in_empty_n = '0; in_dout = '0;
    c_reset = 1'b1; c_en = 1'b0; c_full = 1'b1;
    clear_q();
    repeat (2) @(posedge clk);
    m_owner = -1; m_rr = 0; m_last = 0; m_burst = 0; m_words = 0;

    // reset state
    tick();
    check("rst_word_cnt", word_cnt, 32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_out_write", 32'(out_write), 32'd0);

    // single requester, three words, then rr_ptr=1 shown by a 0-vs-1 tie
    do_reset();
    c_en = 1'b1;
    push(0, 32'h0000_000A); push(0, 32'h0000_000B); push(0, 32'h0000_000C);
    tick();
    check("s1_idle_pick", 32'(grant_valid), 32'd0);
    tick();
    check("s1_write_A", out_din, 32'h0000_000A);
    check("s1_read0", 32'(in_read), 32'b0001);
    tick();
    tick();
    check("s1_write_C", out_din, 32'h0000_000C);
    tick();
    check("s1_release_gv", 32'(grant_valid), 32'd1);
    check("s1_release_wr", 32'(out_write), 32'd0);
    check("s1_word_cnt", word_cnt, 32'd3);
    tick();
    check("s1_idle", 32'(grant_valid), 32'd0);
    push(0, 32'h0000_0D00); push(1, 32'h0000_0D01);
    tick();
    tick();
    check("s1_rr_next_is_1", 32'(grant_idx), 32'd1);
    repeat (5) tick();

    // burst fairness between requesters 0 and 2
    do_reset();
    c_en = 1'b1;
    for (int s = 0; s < 20; s++) begin
      push(0, 32'h0100_0000 + 32'(s));
      push(2, 32'h0300_0000 + 32'(s));
    end
    for (int t = 1; t <= 37; t++) begin
      if (t == 37) c_en = 1'b0;
      tick();
      if (t == 2)  check("s2_first_owner0", 32'(grant_idx), 32'd0);
      if (t == 10) check("s2_idle_gap", 32'(out_write), 32'd0);
      if (t == 11) check("s2_owner2", 32'(grant_idx), 32'd2);
      if (t == 11) check("s2_owner2_data", out_din, 32'h0300_0000);
      if (t == 20) check("s2_back_to0", out_din, 32'h0100_0008);
      if (t == 37) check("s2_word_cnt", word_cnt, 32'd32);
    end
    tick();

    // back-pressure on requester 1
    do_reset();
    c_en = 1'b1;
    for (int s = 0; s < 10; s++) push(1, 32'h0200_0000 + 32'(s));
    for (int t = 1; t <= 13; t++) begin
      c_full = !(t >= 4 && t <= 6);
      if (t == 13) c_en = 1'b0;
      tick();
      if (t == 5) begin
        check("s3_stall_wr", 32'(out_write), 32'd0);
        check("s3_stall_rd", 32'(in_read), 32'd0);
        check("s3_stall_gv", 32'(grant_valid), 32'd1);
        check("s3_stall_cnt", word_cnt, 32'd2);
      end
      if (t == 7)  check("s3_resume", out_din, 32'h0200_0002);
      if (t == 12) check("s3_eighth", out_din, 32'h0200_0007);
      if (t == 13) check("s3_burst_end", word_cnt, 32'd8);
      if (t == 13) check("s3_released", 32'(grant_valid), 32'd0);
    end
    c_full = 1'b1;
    tick();

    // round-robin wrap
    do_reset();
    c_en = 1'b1;
    for (int r = 0; r < NI; r++) push(r, 32'h0500_0000 + 32'(r));
    for (int t = 1; t <= 15; t++) begin
      if (t == 14) push(3, 32'h0500_0033);
      tick();
      if (t == 2)  check("s4_order0", 32'(in_read), 32'b0001);
      if (t == 5)  check("s4_order1", 32'(in_read), 32'b0010);
      if (t == 8)  check("s4_order2", 32'(in_read), 32'b0100);
      if (t == 11) check("s4_order3", 32'(in_read), 32'b1000);
      if (t == 15) check("s4_wrap3", out_din, 32'h0500_0033);
      if (t == 15) check("s4_wrap_cnt", word_cnt, 32'd4);
    end
    repeat (2) tick();

    // reset in the middle of a burst
    do_reset();
    c_en = 1'b1;
    push(1, 32'h0600_0001);
    for (int s = 0; s < 10; s++) push(2, 32'h0700_0000 + 32'(s));
    for (int t = 1; t <= 10; t++) begin
      if (t == 8) begin
        c_reset = 1'b1;
        push(0, 32'h0800_0000);
      end
      if (t == 9) c_reset = 1'b0;
      tick();
      if (t == 7) check("s5_pre_cnt", word_cnt, 32'd3);
      if (t == 8) begin
        check("s5_rst_wr", 32'(out_write), 32'd0);
        check("s5_rst_rd", 32'(in_read), 32'd0);
      end
      if (t == 9) begin
        check("s5_post_gv", 32'(grant_valid), 32'd0);
        check("s5_post_cnt", word_cnt, 32'd0);
      end
      if (t == 10) check("s5_rr_from0", 32'(grant_idx), 32'd0);
    end
    repeat (2) tick();

    // enable gating
    do_reset();
    c_en = 1'b0;
    for (int r = 0; r < NI; r++)
      for (int s = 0; s < 3; s++) push(r, 32'h0900_0000 + 32'(r*16 + s));
    for (int t = 1; t <= 13; t++) begin
      if (t == 5) c_en = 1'b1;
      if (t == 8) c_en = 1'b0;
      tick();
      if (t == 3)  check("s6_gated", 32'(grant_valid), 32'd0);
      if (t == 8)  check("s6_burst_continues", out_din, 32'h0900_0002);
      if (t == 12) check("s6_no_new_grant", 32'(grant_valid), 32'd0);
      if (t == 13) check("s6_word_cnt", word_cnt, 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
